ram_portb_scheduler: RTL and testbench

- Owns port B of the shared dual-port data RAM (11-bit word address, 32-bit data), which until now was read-only for the display adapter.
- Multiplexes two requesters onto that port:
  - Display adapter reads: pipelined, one per cycle, priority.
  - UART bulk loader writes: assembles bytes into words and writes them at auto-incrementing addresses.
- The starvation guard ensures loader writes always complete.
- Sits between the UART receiver, the display adapter and the RAM macro's port B.

---
 rtl/ram_portb_scheduler_pkg.sv | 17 +
 rtl/ram_portb_scheduler_if.sv | 45 ++++
 rtl/ram_portb_scheduler_byte_packer.sv | 52 +++++
 rtl/ram_portb_scheduler.sv | 177 +++++++++++++++++
 tb/tb_ram_portb_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_portb_scheduler_pkg.sv
// Shared types and constants for the RAM port-B scheduler and the display adapter.
// The display adapter's frame window lives at RAM_DISPLAY_BASE for RAM_DISPLAY_WORDS words.
package ram_sched_pkg;

    localparam int RAM_AW = 11;
    localparam int RAM_DW = 32;

    localparam logic [RAM_AW-1:0] RAM_DISPLAY_BASE  = 11'h000;
    localparam int                RAM_DISPLAY_WORDS = 1536;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } loader_state_t;

endpackage

// File: rtl/ram_portb_scheduler_if.sv
// Display, loader and RAM port-B signals of the scheduler, bundled as one interface.
// The slave modport is the scheduler's view; master is the surrounding system's.
interface ram_portb_scheduler_if #(
    parameter int AW = 11
);

    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ready;
    logic          disp_valid;
    logic [31:0]   disp_data;

    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW-1:0] load_words;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          load_busy;
    logic          load_done;
    logic          load_ovf;

    logic [AW-1:0] ram_addr_b;
    logic [31:0]   ram_data_b;
    logic          ram_wren_b;
    logic [31:0]   ram_q_b;

    modport master (
        output disp_req, disp_addr,
        output load_start, load_base, load_words, rx_valid, rx_byte,
        output ram_q_b,
        input  disp_ready, disp_valid, disp_data,
        input  load_busy, load_done, load_ovf,
        input  ram_addr_b, ram_data_b, ram_wren_b
    );

    modport slave (
        input  disp_req, disp_addr,
        input  load_start, load_base, load_words, rx_valid, rx_byte,
        input  ram_q_b,
        output disp_ready, disp_valid, disp_data,
        output load_busy, load_done, load_ovf,
        output ram_addr_b, ram_data_b, ram_wren_b
    );

endinterface

// File: rtl/ram_portb_scheduler_byte_packer.sv
// Little-endian 8-to-32 assembler: bytes fill lanes 0..3, the 4th byte completes the word.
// word/word_valid are combinational on the 4th byte so the caller can latch it that same edge.
module byte_packer
    import ram_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              word_valid,
    output logic [RAM_DW-1:0] word
);

    logic [1:0]  byte_cnt_reg;
    logic [23:0] lanes;
    logic        take;

    assign take = in_valid && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= 2'd0;
        end else if (clr) begin
            byte_cnt_reg <= 2'd0;
        end else if (take) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                end else if (clr) begin
                    lane_reg <= 8'h00;
                end else if (take && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg <= in_byte;
                end
            end

            assign lanes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    assign word_valid = take && (byte_cnt_reg == 2'd3);
    assign word       = {in_byte, lanes};

endmodule

// File: rtl/ram_portb_scheduler.sv
// Port-B owner of the shared data RAM: display reads have priority, UART loader words are
// written at auto-incrementing addresses, and a starvation counter forces a write slot.
module ram_portb_scheduler
    import ram_sched_pkg::*;
#(
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 8,
    parameter int AW         = RAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    ram_portb_scheduler_if.slave bus
);

    localparam int          SW           = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AW:0] FULL_SESSION = {1'b1, {AW{1'b0}}};

    loader_state_t     state_reg, state_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [AW:0]       remaining_reg, remaining_next;
    logic              pend_reg, pend_next;
    logic [RAM_DW-1:0] pend_word_reg, pend_word_next;
    logic              ovf_reg, ovf_next;
    logic [SW-1:0]     starve_cnt_reg;
    logic              done_reg;

    logic [AW-1:0]     ram_addr_b_reg;
    logic [RAM_DW-1:0] ram_data_b_reg;
    logic              ram_wren_b_reg;
    logic [RAM_LAT:0]  rd_vld_reg;
    logic              disp_valid_reg;
    logic [RAM_DW-1:0] disp_data_reg;

    logic              restart;
    logic              force_wr;
    logic              disp_grant;
    logic              wr_grant;
    logic              pk_word_valid;
    logic [RAM_DW-1:0] pk_word;

    // load_start is honoured from IDLE and COLLECT; DONE always falls back to IDLE first.
    assign restart = bus.load_start && (state_reg != DONE);

    assign force_wr       = pend_reg && (starve_cnt_reg == SW'(STARVE_MAX));
    assign bus.disp_ready = !rst && !force_wr;
    assign disp_grant     = bus.disp_req && bus.disp_ready;
    // A restart discards the pending word, so it must not reach the RAM in that cycle.
    assign wr_grant       = pend_reg && !disp_grant && !bus.load_start;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .in_valid   (bus.rx_valid && (state_reg == COLLECT)),
        .in_byte    (bus.rx_byte),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            pend_reg      <= 1'b0;
            pend_word_reg <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            pend_reg      <= pend_next;
            pend_word_reg <= pend_word_next;
            ovf_reg       <= ovf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        pend_next      = pend_reg;
        pend_word_next = pend_word_reg;
        ovf_next       = ovf_reg;

        case (state_reg)
            IDLE, COLLECT: begin
                if (bus.load_start) begin
                    state_next     = COLLECT;
                    addr_next      = bus.load_base;
                    remaining_next = (bus.load_words == '0) ? FULL_SESSION : {1'b0, bus.load_words};
                    pend_next      = 1'b0;
                    ovf_next       = 1'b0;
                end else if (state_reg == COLLECT) begin
                    if (wr_grant) begin
                        addr_next      = addr_reg + 1'b1;
                        remaining_next = remaining_reg - 1'b1;
                        pend_next      = 1'b0;
                    end
                    // The slot is free again if its word issues in this very cycle.
                    if (pk_word_valid) begin
                        if (pend_reg && !wr_grant) begin
                            ovf_next = 1'b1;
                        end else begin
                            pend_next      = 1'b1;
                            pend_word_next = pk_word;
                        end
                    end
                    // A word completing alongside the last write is beyond the session: drop it.
                    if (wr_grant && (remaining_reg == (AW+1)'(1))) begin
                        state_next = DONE;
                        pend_next  = 1'b0;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (!pend_reg || wr_grant) begin
            starve_cnt_reg <= '0;
        end else if (disp_grant) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_b_reg <= '0;
            ram_data_b_reg <= '0;
            ram_wren_b_reg <= 1'b0;
        end else begin
            ram_wren_b_reg <= wr_grant;
            if (disp_grant) begin
                ram_addr_b_reg <= bus.disp_addr;
            end else if (wr_grant) begin
                ram_addr_b_reg <= addr_reg;
                ram_data_b_reg <= pend_word_reg;
            end
        end
    end

    // Bit k marks a read whose address reached the RAM pins k cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_reg     <= '0;
            disp_valid_reg <= 1'b0;
            disp_data_reg  <= '0;
            done_reg       <= 1'b0;
        end else begin
            rd_vld_reg     <= {rd_vld_reg[RAM_LAT-1:0], disp_grant};
            disp_valid_reg <= rd_vld_reg[RAM_LAT];
            if (rd_vld_reg[RAM_LAT]) begin
                disp_data_reg <= bus.ram_q_b;
            end
            done_reg       <= (state_reg == DONE);
        end
    end

    assign bus.disp_valid = disp_valid_reg;
    assign bus.disp_data  = disp_data_reg;
    assign bus.load_busy  = (state_reg != IDLE);
    assign bus.load_done  = done_reg;
    assign bus.load_ovf   = ovf_reg;
    assign bus.ram_addr_b = ram_addr_b_reg;
    assign bus.ram_data_b = ram_data_b_reg;
    assign bus.ram_wren_b = ram_wren_b_reg;

endmodule

// File: tb/tb_ram_portb_scheduler.sv
// Scoreboard bench for ram_portb_scheduler: expected writes/reads are queued at stimulus
// time and retired by a negedge monitor against a behavioural RAM on port B.
module tb_ram_portb_scheduler;
    import ram_sched_pkg::*;

    localparam int AW         = 11;
    localparam int RAM_LAT    = 1;
    localparam int STARVE_MAX = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_portb_scheduler_if #(.AW(AW)) bus ();

    ram_portb_scheduler #(
        .RAM_LAT    (RAM_LAT),
        .STARVE_MAX (STARVE_MAX),
        .AW         (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t exp_wr_q[$];
    rd_t exp_rd_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    int accept_cnt = 0;
    int nr_cnt     = 0;
    int nr_cycle   = -10;
    int nr_acc     = 0;
    int resume_cnt = 0;
    int wr_cnt     = 0;
    int last_wr_cycle = 0;
    int done_cnt   = 0;
    int done_cycle = 0;

    function automatic logic [31:0] pattern(input int a);
        return 32'hA500_0000 ^ 32'(a * 131) ^ (32'(a) << 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Port-B RAM with one cycle read latency; contents restored to the pattern during reset.
    logic [31:0] mem [2048];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pattern(i);
        end else if (bus.ram_wren_b) begin
            mem[bus.ram_addr_b] <= bus.ram_data_b;
        end
        bus.ram_q_b <= mem[bus.ram_addr_b];
    end

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.disp_req && bus.disp_ready) begin
                accept_cnt++;
                if (cycle == nr_cycle + 1) resume_cnt++;
                exp_rd_q.push_back('{data: pattern(int'(bus.disp_addr)), cycle: cycle});
            end
            if (bus.disp_req && !bus.disp_ready) begin
                nr_cnt++;
                nr_cycle = cycle;
                nr_acc   = accept_cnt;
            end
            if (bus.ram_wren_b) begin
                wr_cnt++;
                last_wr_cycle = cycle;
                $display("WR  cyc=%0d addr=0x%03h data=0x%08h", cycle, bus.ram_addr_b, bus.ram_data_b);
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(bus.ram_addr_b), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(bus.ram_addr_b), 32'(e.addr));
                    check("wr_data", bus.ram_data_b, e.data);
                end
            end
            if (bus.disp_valid) begin
                $display("RD  cyc=%0d data=0x%08h", cycle, bus.disp_data);
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", bus.disp_data, 32'hFFFF_FFFF);
                end else begin
                    rd_t r;
                    r = exp_rd_q.pop_front();
                    check("rd_data", bus.disp_data, r.data);
                    check("rd_latency", 32'(cycle - r.cycle), 32'(RAM_LAT + 2));
                end
            end
            if (bus.load_done) begin
                done_cnt++;
                done_cycle = cycle;
                $display("DONE cyc=%0d", cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [AW-1:0] words);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_words = words;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_wr_q.push_back('{addr: a, data: d});
    endtask

    task automatic wait_done(input string tag, input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt > prev), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, acc0, nr0, r0, w0;

        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_words = '0;
        bus.rx_valid   = 1'b0;
        bus.rx_byte    = 8'h00;
        repeat (3) tick();

        check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_wren",       32'(bus.ram_wren_b), 32'd0);
        check("rst_addr",       32'(bus.ram_addr_b), 32'd0);
        check("rst_busy",       32'(bus.load_busy),  32'd0);
        check("rst_done",       32'(bus.load_done),  32'd0);
        check("rst_ovf",        32'(bus.load_ovf),   32'd0);
        check("rst_ready",      32'(bus.disp_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(bus.disp_ready), 32'd1);

        // Basic two-word load, no display traffic.
        d0 = done_cnt;
        start_load(11'h010, 11'd2);
        check("busy_in_session", 32'(bus.load_busy), 32'd1);
        expect_wr(11'h010, 32'h4433_2211);
        expect_wr(11'h011, 32'h8877_6655);
        send_word(32'h4433_2211);
        send_word(32'h8877_6655);
        wait_done("load1_done", d0);
        tick();
        check("done_after_wren", 32'(done_cycle - last_wr_cycle), 32'd1);
        check("busy_fell",       32'(bus.load_busy), 32'd0);
        repeat (3) tick();
        check("done_single_pulse", 32'(done_cnt - d0), 32'd1);
        check("load1_wr_drained",  32'(exp_wr_q.size()), 32'd0);

        // Back-to-back display reads.
        acc0 = accept_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.disp_req  = 1'b1;
            bus.disp_addr = 11'(i);
            tick();
        end
        bus.disp_req = 1'b0;
        repeat (6) tick();
        check("reads_accepted", 32'(accept_cnt - acc0), 32'd4);
        check("reads_drained",  32'(exp_rd_q.size()), 32'd0);

        // Starvation guard: display hogs the port while one word is pending.
        d0 = done_cnt;
        start_load(11'h200, 11'd1);
        expect_wr(11'h200, 32'hDEAD_BEEF);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h100;
        nr0 = nr_cnt;
        r0  = resume_cnt;
        send_word(32'hDEAD_BEEF);
        acc0 = accept_cnt;
        for (int n = 0; n < 40 && nr_cnt == nr0; n++) tick();
        repeat (3) tick();
        bus.disp_req = 1'b0;
        check("starve_accepts",  32'(nr_acc - acc0), 32'(STARVE_MAX));
        check("starve_nr_once",  32'(nr_cnt - nr0), 32'd1);
        check("forced_wr_slot",  32'(last_wr_cycle - nr_cycle), 32'd1);
        check("display_resumes", 32'(resume_cnt - r0), 32'd1);
        wait_done("starve_done", d0);
        repeat (5) tick();
        check("starve_rd_drained", 32'(exp_rd_q.size()), 32'd0);

        // Address wrap at the top of the RAM.
        d0 = done_cnt;
        start_load(11'h7FF, 11'd2);
        expect_wr(11'h7FF, 32'hCAFE_0001);
        expect_wr(11'h000, 32'hCAFE_0002);
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        wait_done("wrap_done", d0);
        check("wrap_wr_drained", 32'(exp_wr_q.size()), 32'd0);

        // Overflow: second word completes while the first is still starved.
        start_load(11'h300, 11'd2);
        expect_wr(11'h300, 32'h0403_0201);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h101;
        send_word(32'h0403_0201);
        send_word(32'h0807_0605);
        tick();
        check("ovf_set", 32'(bus.load_ovf), 32'd1);
        bus.disp_req = 1'b0;
        repeat (15) tick();
        check("ovf_sticky",        32'(bus.load_ovf), 32'd1);
        check("ovf_still_busy",    32'(bus.load_busy), 32'd1);
        check("ovf_first_written", 32'(exp_wr_q.size()), 32'd0);
        d0 = done_cnt;
        start_load(11'h310, 11'd1);
        check("ovf_cleared", 32'(bus.load_ovf), 32'd0);
        expect_wr(11'h310, 32'h1234_5678);
        send_word(32'h1234_5678);
        wait_done("ovf_restart_done", d0);

        // Reset in the middle of a session with two reads in flight.
        start_load(11'h320, 11'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h002;
        tick();
        tick();
        bus.disp_req = 1'b0;
        rst = 1'b1;
        exp_rd_q.delete();
        w0 = wr_cnt;
        #2;
        check("midrst_wren",  32'(bus.ram_wren_b), 32'd0);
        check("midrst_busy",  32'(bus.load_busy),  32'd0);
        check("midrst_valid", 32'(bus.disp_valid), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check("midrst_no_wr",   32'(wr_cnt - w0),    32'd0);
        check("midrst_no_read", 32'(exp_rd_q.size()), 32'd0);
        check("midrst_idle",    32'(bus.load_busy),  32'd0);

        d0 = done_cnt;
        start_load(11'h330, 11'd1);
        expect_wr(11'h330, 32'h5566_7788);
        send_word(32'h5566_7788);
        wait_done("post_rst_done", d0);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h003;
        tick();
        bus.disp_req = 1'b0;
        repeat (6) tick();
        check("final_wr_drained", 32'(exp_wr_q.size()), 32'd0);
        check("final_rd_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
